// File: rtl/uart_rx_only.sv
// 8N1 asynchronous receiver with 16x fractional-accumulator oversampling.
// Holds each accepted byte until the host acknowledges it.
`timescale 1ns/1ps
module uart_rx_only #(
  parameter int CLK_HZ = 68_000_000,
  parameter int BAUD   = 115_200,
  parameter int ACC_W  = 29
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  output logic       uart_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [ACC_W-1:0] STEP_NEG =
    ACC_W'(16 * BAUD);
  localparam logic [ACC_W-1:0] STEP_POS =
    ACC_W'(16 * BAUD - CLK_HZ);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] sync_q;
  logic       rx_s;
  logic [ACC_W-1:0] acc_q;
  logic       tick;
  logic [3:0] os_q;
  logic [3:0] os_d;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  logic [7:0] shifter_q;
  logic       shift_en;
  logic       load;
  logic       ovr_set;
  logic       ferr_set;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  assign rx_s = sync_q[1];

  // Sign of the accumulator marks a tick; average rate is 16*BAUD.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_q + (acc_q[ACC_W-1] ? STEP_NEG : STEP_POS);
    end
  end

  assign tick = ~acc_q[ACC_W-1];

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) state_d = START;
        end
        START: begin
          if (os_q == 4'd7) state_d = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (os_q == 4'd15 && bit_q == 3'd7) state_d = STOP;
        end
        STOP: begin
          if (os_q == 4'd15) state_d = rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    os_d     = os_q;
    bit_d    = bit_q;
    shift_en = 1'b0;
    load     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    if (tick) begin
      unique case (1'b1)
        (state_q == IDLE): begin
          os_d = '0;
        end
        (state_q == START): begin
          os_d  = (os_q == 4'd7) ? 4'd0 : os_q + 4'd1;
          bit_d = '0;
        end
        (state_q == DATA): begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            shift_en = 1'b1;
            if (bit_q != 3'd7) bit_d = bit_q + 3'd1;
          end
        end
        (state_q == STOP): begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            if (!rx_s) begin
              ferr_set = 1'b1;
            end else if (!uart_valid_o || uart_rd_i) begin
              load = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      os_q             <= '0;
      bit_q            <= '0;
      shifter_q        <= '0;
      uart_dat_o       <= '0;
      uart_valid_o     <= 1'b0;
      uart_frame_err_o <= 1'b0;
      uart_overrun_o   <= 1'b0;
      uart_busy        <= 1'b0;
    end else begin
      os_q  <= os_d;
      bit_q <= bit_d;
      if (shift_en) shifter_q <= {rx_s, shifter_q[7:1]};
      if (load) uart_dat_o <= shifter_q;
      // A load outranks a simultaneous read acknowledge.
      if (load) begin
        uart_valid_o <= 1'b1;
      end else if (uart_rd_i) begin
        uart_valid_o <= 1'b0;
      end
      uart_frame_err_o <= ferr_set;
      uart_overrun_o   <= ovr_set;
      uart_busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_only.sv
// Bench for uart_rx_only: random and directed 8N1 frames
// checked through an event scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_only;

  localparam int  CLK_HZ = 68_000_000;
  localparam int  BAUD   = 1_152_000;
  localparam int  ACC_W  = 29;
  localparam real BIT_CLKS  = real'(CLK_HZ) / real'(BAUD);
  localparam real TICK_CLKS = real'(CLK_HZ) / (16.0 * real'(BAUD));

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  uart_rx_only #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .ACC_W(ACC_W)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_n_i(rst_n),
    .uart_rx(rx),
    .uart_rd_i(rd),
    .uart_dat_o(dat),
    .uart_valid_o(valid),
    .uart_frame_err_o(ferr),
    .uart_overrun_o(ovr),
    .uart_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_BYTE, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       model_valid = 1'b0;
  logic [7:0] model_dat = 8'h00;
  int         busy_low_cnt = 0;
  int         load_cyc = -1;
  int         ovr_cyc = -1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Host-visible consequence of one frame, from the receiver's rules.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok);
    if (!stop_ok) begin
      push_ev(EV_FERR, model_dat);
    end else if (model_valid) begin
      push_ev(EV_OVR, model_dat);
    end else begin
      model_valid = 1'b1;
      model_dat   = d;
      push_ev(EV_BYTE, d);
    end
  endtask

  task automatic mon_event(input ev_kind_t k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s dat=%02h, want none",
               k.name(), dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== dat) begin
        n_bad++;
        $display("FAIL event: got %s dat=%02h, want %s dat=%02h",
                 k.name(), dat, e.kind.name(), e.data);
      end
    end
  endtask

  logic       prev_valid = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_dat   = 8'h00;
    end else begin
      if (ferr) mon_event(EV_FERR);
      if (ovr) begin
        ovr_cyc = cyc;
        mon_event(EV_OVR);
      end
      if (valid && (!prev_valid || dat != prev_dat)) begin
        load_cyc = cyc;
        mon_event(EV_BYTE);
      end
      prev_valid = valid;
      prev_dat   = dat;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic tx_frame(input logic [7:0] d, input real len,
                          input bit stop_bit, output int t0);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      wait_until(t0 + int'(len * real'(k + 1)));
      if (k <= 8 && !busy) busy_low_cnt++;
    end
  endtask

  task automatic send(input logic [7:0] d, input real len,
                      input bit stop_ok);
    int t0;
    model_frame(d, stop_ok);
    tx_frame(d, len, stop_ok, t0);
  endtask

  task automatic host_read();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rd_clears_valid", valid, 0);
    model_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    rd    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n       = 1'b1;
    model_valid = 1'b0;
    model_dat   = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   t;
    int   lat;
    int   lo;
    int   hi;
    int   r0;
    int   offs;
    real  len;
    logic [7:0] d;
    logic [9:0] bits;
    bit   ok;

    #1;
    do_reset();
    check("reset_dat", dat, 0);
    check("reset_valid", valid, 0);
    check("reset_ferr", ferr, 0);
    check("reset_ovr", ovr, 0);
    check("reset_busy", busy, 0);
    repeat (20) @(negedge clk);

    busy_low_cnt = 0;
    load_cyc = -1;
    model_frame(8'h55, 1'b1);
    tx_frame(8'h55, BIT_CLKS, 1'b1, t0);
    check("busy_in_frame", busy_low_cnt, 0);
    check("busy_after_load", busy, 0);
    check("valid_55", valid, 1);
    lat = load_cyc - t0;
    lo  = int'(9.5 * BIT_CLKS - TICK_CLKS);
    hi  = int'(9.5 * BIT_CLKS + 4.0 + 2.0 * TICK_CLKS);
    n_cmp++;
    if (lat < lo || lat > hi) begin
      n_bad++;
      $display("FAIL latency: got %0d clks, want %0d..%0d", lat, lo, hi);
    end
    host_read();
    repeat (20) @(negedge clk);

    t = cyc;
    rx = 1'b0;
    wait_until(t + 20);
    rx = 1'b1;
    wait_until(t + 25);
    check("glitch_busy_on", busy, 1);
    wait_until(t + 90);
    check("glitch_busy_off", busy, 0);
    check("glitch_no_valid", valid, 0);

    send(8'hA3, BIT_CLKS, 1'b0);
    wait_until(cyc + int'(3.0 * BIT_CLKS));
    check("wait_high_busy", busy, 1);
    check("ferr_no_valid", valid, 0);
    rx = 1'b1;
    wait_until(cyc + 15);
    check("wait_high_exit", busy, 0);
    wait_until(cyc + int'(BIT_CLKS));
    send(8'h3C, BIT_CLKS, 1'b1);
    host_read();

    do_reset();
    r0 = cyc;
    ovr_cyc = -1;
    wait_until(r0 + 20);
    send(8'h01, BIT_CLKS, 1'b1);
    send(8'h02, BIT_CLKS, 1'b1);
    check("ovr_keeps_dat", dat, 8'h01);
    offs = ovr_cyc - r0;
    repeat (20) @(negedge clk);

    do_reset();
    r0 = cyc;
    wait_until(r0 + 20);
    send(8'h01, BIT_CLKS, 1'b1);
    push_ev(EV_BYTE, 8'h03);
    model_valid = 1'b1;
    model_dat   = 8'h03;
    fork
      tx_frame(8'h03, BIT_CLKS, 1'b1, t0);
      begin
        wait_until(r0 + offs - 1);
        rd = 1'b1;
        wait_until(r0 + offs);
        rd = 1'b0;
        check("load_wins_valid", valid, 1);
        check("load_wins_dat", dat, 8'h03);
      end
    join
    repeat (10) @(negedge clk);
    check("valid_held", valid, 1);

    t = cyc;
    bits = {1'b1, 8'hC5, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx = bits[k];
      wait_until(t + int'(BIT_CLKS * real'(k + 1)));
    end
    rx = bits[5];
    wait_until(t + int'(BIT_CLKS * 5.5));
    check("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dat", dat, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ferr", ferr, 0);
    check("async_rst_ovr", ovr, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_valid = 1'b0;
    model_dat   = 8'h00;
    repeat (20) @(negedge clk);
    send(8'h81, BIT_CLKS, 1'b1);
    host_read();

    for (int s = 0; s < 2; s++) begin
      len = (s == 0) ? BIT_CLKS / 1.02 : BIT_CLKS / 0.98;
      send(8'hFF, len, 1'b1);
      host_read();
      send(8'h00, len, 1'b1);
      host_read();
      send(8'h80, len, 1'b1);
      host_read();
    end

    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      len = BIT_CLKS * (0.981 + real'($urandom_range(0, 380)) / 10000.0);
      ok  = ($urandom_range(0, 4) != 0);
      send(d, len, ok);
      if (!ok) begin
        wait_until(cyc + int'(len * real'($urandom_range(0, 2))));
        rx = 1'b1;
        wait_until(cyc + 12);
      end
      wait_until(cyc + $urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) host_read();
    end

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
